// File: rtl/rv32i_types.sv
// Shared RV32I type package.
// Holds the branch resolve unit FSM encoding, the predictor update codes
// (also consumed by the fetch gshare predictor) and the queued prediction
// entry layout.
package rv32i_types;

   typedef enum logic [0:0] {
      BRU_IDLE     = 1'b0,
      BRU_REDIRECT = 1'b1
   } bru_state_t;

   // Predictor update encoding on branch_was_taken.
   localparam logic [1:0] BR_UPD_TAKEN     = 2'b10;
   localparam logic [1:0] BR_UPD_NOT_TAKEN = 2'b01;
   localparam logic [1:0] BR_UPD_NONE      = 2'b00;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } bru_pred_entry_t;

   function automatic logic [1:0] br_upd_code(input logic taken);
      return taken ? BR_UPD_TAKEN : BR_UPD_NOT_TAKEN;
   endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// Circular prediction queue for the branch resolve unit.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i at the tail (ignored when full)
//   push_data_i  : prediction entry to enqueue
//   pop_i        : drop the head entry (ignored when empty)
//   clear_i      : synchronous flush; wins over push and pop
//   head_o       : entry at the read pointer
//   count_o      : number of valid entries (0..DEPTH)
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module bru_pred_fifo
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  bru_pred_entry_t push_data_i,
   input  logic            pop_i,
   input  logic            clear_i,
   output bru_pred_entry_t head_o,
   output logic [PTR_W:0]  count_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

   bru_pred_entry_t mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == FullCount);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push_i && !full_o;
      pop_ok   = pop_i && !empty_o;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by plain overflow.
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_ok && !pop_ok)      count_d = count_q + (PTR_W + 1)'(1);
         else if (pop_ok && !push_ok) count_d = count_q - (PTR_W + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: execute-stage partner of the fetch gshare predictor.
// Queues predictions from fetch in order, checks each against the execute
// outcome, drives the predictor update, and on a misprediction flushes the
// queue and raises a redirect to fetch via a valid/ready handshake.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   pred_valid/pc/taken/target     : prediction push from fetch
//   pred_ready                     : queue accepts a push (registered-state only)
//   res_valid/pc/taken/target      : resolution of the oldest in-flight branch
//   completed_branch_addr          : predictor update PC (1 cycle after resolve)
//   branch_was_taken               : 2'b10 taken, 2'b01 not taken, 2'b00 none
//   redirect_valid/pc/ready        : redirect handshake to fetch
//   order_err                      : sticky resolve-ordering error
//   perf_branches/perf_mispredicts : only when BRU_PERF_CNT_EN is defined
// Configuration macro: BRU_PERF_CNT_EN adds saturating performance counters.
module branch_resolve_unit
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   input  logic        pred_taken,
   input  logic [31:0] pred_target,
   output logic        pred_ready,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   output logic [31:0] completed_branch_addr,
   output logic [1:0]  branch_was_taken,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        order_err
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts
`endif
);

   bru_state_t      state_q, state_d;
   logic [31:0]     redirect_pc_q, redirect_pc_d;
   logic [31:0]     upd_addr_q, upd_addr_d;
   logic [1:0]      upd_code_q, upd_code_d;
   logic            order_err_q, order_err_d;

   bru_pred_entry_t push_entry;
   bru_pred_entry_t fifo_head;
   logic [PTR_W:0]  fifo_count;
   logic            fifo_full, fifo_empty;
   logic            push, res_accept, mispredict;

   assign push_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};

   // Depends on registered state only, so fetch never sees a comb path.
   assign pred_ready = !fifo_full && (state_q == BRU_IDLE);

   always_comb begin
      push       = pred_valid && pred_ready;
      res_accept = (state_q == BRU_IDLE) && res_valid && !fifo_empty;
      // A not-taken branch has no meaningful target, so only compare it on taken.
      mispredict = res_accept &&
                   ((res_taken != fifo_head.taken) ||
                    (res_taken && (res_target != fifo_head.target)));
   end

   bru_pred_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (res_accept),
      .clear_i     (mispredict),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         BRU_IDLE: begin
            if (mispredict) begin
               state_d       = BRU_REDIRECT;
               redirect_pc_d = res_taken ? res_target : res_pc + 32'd4;
            end
         end
         BRU_REDIRECT: begin
            if (redirect_ready) state_d = BRU_IDLE;
         end
         default: state_d = BRU_IDLE;
      endcase
   end

   always_comb begin
      upd_addr_d  = res_accept ? res_pc : 32'd0;
      upd_code_d  = res_accept ? br_upd_code(res_taken) : BR_UPD_NONE;
      // Resolve while empty is dropped; a PC mismatch still pops and updates.
      order_err_d = order_err_q ||
                    ((state_q == BRU_IDLE) && res_valid &&
                     (fifo_empty || (res_pc != fifo_head.pc)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= BRU_IDLE;
         redirect_pc_q <= 32'd0;
         upd_addr_q    <= 32'd0;
         upd_code_q    <= BR_UPD_NONE;
         order_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         upd_addr_q    <= upd_addr_d;
         upd_code_q    <= upd_code_d;
         order_err_q   <= order_err_d;
      end
   end

   assign completed_branch_addr = upd_addr_q;
   assign branch_was_taken      = upd_code_q;
   assign redirect_valid        = (state_q == BRU_REDIRECT);
   assign redirect_pc           = redirect_pc_q;
   assign order_err             = order_err_q;

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_q, perf_mp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_br_q <= 32'd0;
         perf_mp_q <= 32'd0;
      end else begin
         if (res_accept && (perf_br_q != 32'hFFFF_FFFF)) perf_br_q <= perf_br_q + 32'd1;
         if (mispredict && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_q <= perf_mp_q + 32'd1;
      end
   end

   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit.
module tb_branch_resolve_unit;

   logic        clk;
   logic        rst;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        pred_ready;
   logic        res_valid;
   logic [31:0] res_pc;
   logic        res_taken;
   logic [31:0] res_target;
   logic [31:0] completed_branch_addr;
   logic [1:0]  branch_was_taken;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        order_err;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;
`endif

   int n_cmp = 0;
   int n_err = 0;

   branch_resolve_unit #(
      .DEPTH (8)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .pred_valid            (pred_valid),
      .pred_pc               (pred_pc),
      .pred_taken            (pred_taken),
      .pred_target           (pred_target),
      .pred_ready            (pred_ready),
      .res_valid             (res_valid),
      .res_pc                (res_pc),
      .res_taken             (res_taken),
      .res_target            (res_target),
      .completed_branch_addr (completed_branch_addr),
      .branch_was_taken      (branch_was_taken),
      .redirect_valid        (redirect_valid),
      .redirect_pc           (redirect_pc),
      .redirect_ready        (redirect_ready),
      .order_err             (order_err)
`ifdef BRU_PERF_CNT_EN
      ,
      .perf_branches         (perf_branches),
      .perf_mispredicts      (perf_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pred(input logic v, input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt);
      pred_valid  = v;
      pred_pc     = pc;
      pred_taken  = t;
      pred_target = tgt;
   endtask

   task automatic set_res(input logic v, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt);
      res_valid  = v;
      res_pc     = pc;
      res_taken  = t;
      res_target = tgt;
   endtask

   function automatic logic [31:0] cnt();
      return 32'(dut.fifo_count);
   endfunction

   initial begin
      rst            = 1'b1;
      redirect_ready = 1'b0;
      set_pred(1'b0, 32'd0, 1'b0, 32'd0);
      set_res(1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_pred_ready", 32'(pred_ready), 32'd1);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_bwt", 32'(branch_was_taken), 32'd0);
      chk("rst_addr", completed_branch_addr, 32'd0);
      chk("rst_order_err", 32'(order_err), 32'd0);
      chk("rst_count", cnt(), 32'd0);

      // Correct taken prediction
      set_pred(1'b1, 32'h100, 1'b1, 32'h140);
      tick();
      set_pred(1'b0, 32'd0, 1'b0, 32'd0);
      chk("t1_count_push", cnt(), 32'd1);
      set_res(1'b1, 32'h100, 1'b1, 32'h140);
      tick();
      set_res(1'b0, 32'd0, 1'b0, 32'd0);
      chk("t1_bwt", 32'(branch_was_taken), 32'h2);
      chk("t1_addr", completed_branch_addr, 32'h100);
      chk("t1_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("t1_count", cnt(), 32'd0);
      tick();
      chk("t1_bwt_one_cycle", 32'(branch_was_taken), 32'd0);

      // Predicted not-taken, actually taken -> redirect to target
      set_pred(1'b1, 32'h200, 1'b0, 32'h204);
      tick();
      set_pred(1'b0, 32'd0, 1'b0, 32'd0);
      set_res(1'b1, 32'h200, 1'b1, 32'h280);
      tick();
      set_res(1'b0, 32'd0, 1'b0, 32'd0);
      chk("t2_bwt", 32'(branch_was_taken), 32'h2);
      chk("t2_addr", completed_branch_addr, 32'h200);
      chk("t2_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("t2_redirect_pc", redirect_pc, 32'h280);
      chk("t2_pred_ready", 32'(pred_ready), 32'd0);
      chk("t2_count", cnt(), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_redirect_hold", 32'(redirect_valid), 32'd1);
      end
      chk("t2_bwt_hold_none", 32'(branch_was_taken), 32'd0);
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      chk("t2_redirect_drop", 32'(redirect_valid), 32'd0);
      chk("t2_pred_ready_back", 32'(pred_ready), 32'd1);

      // Fill the queue with not-taken predictions
      for (int i = 0; i < 8; i++) begin
         set_pred(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
         tick();
      end
      chk("t3_full_pred_ready", 32'(pred_ready), 32'd0);
      chk("t3_full_count", cnt(), 32'd8);
      // Resolve head while pushing into a full queue: push is refused
      set_pred(1'b1, 32'h2000, 1'b0, 32'h0);
      set_res(1'b1, 32'h1000, 1'b0, 32'h0);
      tick();
      set_res(1'b0, 32'd0, 1'b0, 32'd0);
      set_pred(1'b0, 32'd0, 1'b0, 32'd0);
      chk("t3_full_pop_count", cnt(), 32'd7);
      chk("t3_full_pop_ready", 32'(pred_ready), 32'd1);
      chk("t3_full_pop_bwt", 32'(branch_was_taken), 32'h1);
      chk("t3_full_pop_addr", completed_branch_addr, 32'h1000);
      // 20 simultaneous push/pop pairs walk the pointers round several times
      for (int k = 0; k < 20; k++) begin
         set_pred(1'b1, 32'h1020 + 32'(4 * k), 1'b0, 32'h0);
         set_res(1'b1, 32'h1004 + 32'(4 * k), 1'b0, 32'h0);
         tick();
         chk("t3_wrap_count", cnt(), 32'd7);
         chk("t3_wrap_addr", completed_branch_addr, 32'h1004 + 32'(4 * k));
         chk("t3_wrap_bwt", 32'(branch_was_taken), 32'h1);
      end
      set_pred(1'b0, 32'd0, 1'b0, 32'd0);
      for (int k = 0; k < 7; k++) begin
         set_res(1'b1, 32'h1054 + 32'(4 * k), 1'b0, 32'h0);
         tick();
         chk("t3_drain_addr", completed_branch_addr, 32'h1054 + 32'(4 * k));
      end
      set_res(1'b0, 32'd0, 1'b0, 32'd0);
      chk("t3_drain_count", cnt(), 32'd0);
      chk("t3_order_err", 32'(order_err), 32'd0);
      chk("t3_redirect_valid", 32'(redirect_valid), 32'd0);

      // Queue of 3, head mispredicts (pred taken, actual not taken)
      set_pred(1'b1, 32'h300, 1'b1, 32'h340);
      tick();
      set_pred(1'b1, 32'h310, 1'b0, 32'h0);
      tick();
      set_pred(1'b1, 32'h320, 1'b0, 32'h0);
      tick();
      chk("t4_count3", cnt(), 32'd3);
      // Push in the mispredict cycle must be discarded by the flush
      set_pred(1'b1, 32'h330, 1'b0, 32'h0);
      set_res(1'b1, 32'h300, 1'b0, 32'h0);
      tick();
      set_pred(1'b0, 32'd0, 1'b0, 32'd0);
      chk("t4_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("t4_redirect_pc", redirect_pc, 32'h304);
      chk("t4_count_flush", cnt(), 32'd0);
      chk("t4_bwt", 32'(branch_was_taken), 32'h1);
      chk("t4_addr", completed_branch_addr, 32'h300);
      // Wrong-path resolve while redirecting is ignored
      set_res(1'b1, 32'h310, 1'b0, 32'h0);
      tick();
      set_res(1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      chk("t4_redir_res_bwt", 32'(branch_was_taken), 32'd0);
      chk("t4_redir_res_err", 32'(order_err), 32'd0);
      chk("t4_redir_res_count", cnt(), 32'd0);
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      chk("t4_redirect_drop", 32'(redirect_valid), 32'd0);

      // Resolve with empty queue -> sticky order_err, no update
      set_res(1'b1, 32'h400, 1'b1, 32'h440);
      tick();
      set_res(1'b0, 32'd0, 1'b0, 32'd0);
      chk("t5_order_err", 32'(order_err), 32'd1);
      chk("t5_bwt_none", 32'(branch_was_taken), 32'd0);
      chk("t5_count", cnt(), 32'd0);
      tick();
      tick();
      chk("t5_order_err_sticky", 32'(order_err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_order_err_rst", 32'(order_err), 32'd0);

      // Reset while redirecting
      set_pred(1'b1, 32'h500, 1'b1, 32'h540);
      tick();
      set_pred(1'b0, 32'd0, 1'b0, 32'd0);
      set_res(1'b1, 32'h500, 1'b0, 32'h0);
      tick();
      set_res(1'b0, 32'd0, 1'b0, 32'd0);
      chk("t6_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("t6_redirect_pc", redirect_pc, 32'h504);
`ifdef BRU_PERF_CNT_EN
      chk("t6_perf_br", perf_branches, 32'd1);
      chk("t6_perf_mp", perf_mispredicts, 32'd1);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("t6_rst_count", cnt(), 32'd0);
      chk("t6_rst_pred_ready", 32'(pred_ready), 32'd1);
      chk("t6_rst_redirect_pc", redirect_pc, 32'd0);
`ifdef BRU_PERF_CNT_EN
      chk("t6_rst_perf_br", perf_branches, 32'd0);
      chk("t6_rst_perf_mp", perf_mispredicts, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
